health_bar_ctrl: RTL and testbench
==================================

# health_bar_ctrl

Per-player health bar controller feeding the pixel color stage. It holds one fighter's health, applies damage hits, and animates the round-intro fill and the lagging red damage trail. It drives the green (current health) and red (trail) bar widths plus the lose flag consumed by the color mux. The top level instantiates one copy per player.

## Interface
- MAX_W, 100: full bar width in pixels, equal to full health.
- FILL_STEP, 2: pixels added per frame tick during the round-intro fill.
- DRAIN_STEP, 1: pixels removed per frame tick from the red trail.
- TRAIL_DELAY, 30: frame ticks between the last accepted hit and the start of trail drain.
- INVULN_FRAMES, 20: frame ticks after an accepted hit during which further hits are ignored.

- CLK  in  1  system clock, single domain.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-CLK pulse per video frame (vsync-derived, already synchronous).
- round_start  in  1  one-CLK pulse; restarts the round.
- hit_valid  in  1  one-CLK damage request.
- hit_dmg  in  7  damage in pixels, 0..127.
- greensizex  out  10  current health width, 0..MAX_W.
- redsizex  out  10  trail width; always ≥ greensizex.
- fight_active  out  1  high only in FIGHT.
- hit_ack  out  1  one-CLK pulse when a hit is accepted.
- lose  out  1  high in LOSE.

## Operation
- States:
  - IDLE: both widths 0. Waits for round_start.
  - FILL: widths grow together.
  - FIGHT: hits are accepted.
  - KO_DRAIN: health is 0; the trail drains.
  - LOSE: terminal for the round.
- Any state + round_start → FILL. Widths go to 0, counters clear, lose clears. round_start has priority over hit_valid and frame_tick in the same cycle.
- FILL:
  - On each frame_tick, green = red = min(green + FILL_STEP, MAX_W).
  - Transition to FIGHT on the tick that reaches MAX_W.
  - hit_valid is ignored.
- FIGHT: a hit is accepted when hit_valid = 1 and the invuln counter = 0. On acceptance:
  - green ← green − hit_dmg, saturating at 0.
  - hit_ack = 1.
  - invuln counter ← INVULN_FRAMES.
  - trail counter ← TRAIL_DELAY. It reloads on every accepted hit.
  - Next state is KO_DRAIN if the new green = 0, else FIGHT.
- A hit with hit_dmg = 0 is still accepted: ack, counters load, health unchanged.
- Invuln counter: decrements on each frame_tick when nonzero. It does not decrement in the cycle it is loaded, even if frame_tick is also high in that cycle.
- Trail counter, on each frame_tick:
  - If nonzero, decrement.
  - Else, if red > green, red ← red − min(DRAIN_STEP, red − green). Red never goes below green.
  - It does not decrement in the cycle it is loaded.
- KO_DRAIN:
  - Hits are ignored.
  - The trail counter and drain continue as in FIGHT.
  - Transition to LOSE in the cycle after red reaches 0.
- LOSE: lose = 1, widths 0. Held until round_start.
- Width arithmetic: 10-bit unsigned. Subtraction uses an 11-bit intermediate, clamped at 0. Addition is clamped at MAX_W.

## Timing
- Reset values:
  - state IDLE.
  - greensizex, redsizex = 0.
  - fight_active, hit_ack, lose = 0.
  - both counters 0.
- All outputs are registered.
- Hit latency: hit accepted at edge n → greensizex and hit_ack valid after edge n. hit_ack is high for exactly one cycle.
- Per-tick updates: all frame-tick effects (fill, drain, counter decrements) apply at the edge where frame_tick = 1.
- Hit and frame_tick in the same cycle: the hit takes effect, the counters load, and no drain step occurs.
- Reset_n asserted mid-fill or mid-drain: immediate return to reset values. No completion of the fill or drain.
- Trail timing: first drain step occurs on the (TRAIL_DELAY+1)-th frame_tick after acceptance.

## Structure
- Shared package health_pkg:
  - hb_state_t enum {IDLE, FILL, FIGHT, KO_DRAIN, LOSE}.
  - Default parameter constants.
  - 10-bit width typedef.
- Natural sub-module: hb_trail. It holds the trail counter and the red-width drain logic. Inputs: frame_tick, load, green width. Output: red width.
- The top level owns the FSM, health register and invuln counter.

## Test plan
- Reset, then round_start, then 50 frame_ticks → widths step 2,4,…,100. fight_active rises at the tick reaching 100.
- Hit of 30 in FIGHT → green 70 next cycle, hit_ack pulse, red holds 100 for 30 ticks. Red then reaches 70 after 30 more ticks.
- Second hit of 10 within 20 ticks of the first → no hit_ack, green unchanged. Same hit at tick 21 → accepted, green 60, trail delay restarts.
- Hit of 127 at green 40 → green 0, state KO_DRAIN. lose rises the cycle after red drains to 0.
- round_start, hit_valid and frame_tick asserted in the same cycle while in LOSE → FILL, widths 0, no hit_ack, lose clears.
- Reset_n low for 1 cycle mid-trail-drain → all outputs 0 immediately, state IDLE. A hit afterwards is ignored.

Source files
------------

// File: rtl/health_bar_ctrl_pkg.sv
// Shared types and default constants for the per-player health bar controller.
package health_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    FIGHT,
    KO_DRAIN,
    LOSE
  } hb_state_t;

  localparam int WIDTH_W = 10;
  typedef logic [WIDTH_W-1:0] hb_width_t;

  localparam int MAX_W_DEF         = 100;
  localparam int FILL_STEP_DEF     = 2;
  localparam int DRAIN_STEP_DEF    = 1;
  localparam int TRAIL_DELAY_DEF   = 30;
  localparam int INVULN_FRAMES_DEF = 20;

endpackage

// File: rtl/health_bar_ctrl_trail.sv
// Red damage trail: holds the trail delay counter and drains red toward green.
module hb_trail
  import health_pkg::*;
#(
  parameter int TRAIL_DELAY = TRAIL_DELAY_DEF,
  parameter int DRAIN_STEP  = DRAIN_STEP_DEF
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       clr,
  input  logic       load,
  input  logic       track,
  input  logic       run,
  input  logic [9:0] green_w,
  output logic [9:0] red_w
);

  localparam int TR_W = $clog2(TRAIL_DELAY + 1);
  localparam logic [TR_W-1:0] TR_LOAD = TR_W'(TRAIL_DELAY);
  localparam hb_width_t STEP = hb_width_t'(DRAIN_STEP);

  logic [TR_W-1:0] cnt_q;
  hb_width_t       red_q;

  // Pixels to remove this tick: never more than the gap down to green.
  function automatic hb_width_t drain_amt(hb_width_t red, hb_width_t green);
    hb_width_t gap;
    gap = (red > green) ? (red - green) : '0;
    return (gap > STEP) ? STEP : gap;
  endfunction

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
      red_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
      red_q <= '0;
    end else if (track) begin
      cnt_q <= '0;
      red_q <= green_w;
    end else if (load) begin
      cnt_q <= TR_LOAD;
    end else if (run && frame_tick) begin
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      else             red_q <= red_q - drain_amt(red_q, green_w);
    end
  end

  assign red_w = red_q;

endmodule

// File: rtl/health_bar_ctrl.sv
// One fighter's health bar: FSM, health register, invulnerability window and registered outputs.
module health_bar_ctrl
  import health_pkg::*;
#(
  parameter int MAX_W         = MAX_W_DEF,
  parameter int FILL_STEP     = FILL_STEP_DEF,
  parameter int DRAIN_STEP    = DRAIN_STEP_DEF,
  parameter int TRAIL_DELAY   = TRAIL_DELAY_DEF,
  parameter int INVULN_FRAMES = INVULN_FRAMES_DEF
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       round_start,
  input  logic       hit_valid,
  input  logic [6:0] hit_dmg,
  output logic [9:0] greensizex,
  output logic [9:0] redsizex,
  output logic       fight_active,
  output logic       hit_ack,
  output logic       lose
);

  localparam int IV_W = $clog2(INVULN_FRAMES + 1);
  localparam logic [IV_W-1:0] IV_LOAD = IV_W'(INVULN_FRAMES);
  localparam hb_width_t MAX_V  = hb_width_t'(MAX_W);
  localparam hb_width_t FILL_V = hb_width_t'(FILL_STEP);

  hb_state_t       state_q, state_nxt;
  hb_width_t       green_q, green_nxt;
  logic [IV_W-1:0] inv_q, inv_nxt;
  logic            ack_q, fight_q, lose_q;
  logic            accept, clr, track, run;
  hb_width_t       red_w;

  function automatic hb_width_t sat_add(hb_width_t a, hb_width_t b);
    logic [WIDTH_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, MAX_V}) ? MAX_V : s[WIDTH_W-1:0];
  endfunction

  function automatic hb_width_t sat_sub(hb_width_t a, hb_width_t b);
    logic [WIDTH_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[WIDTH_W] ? '0 : d[WIDTH_W-1:0];
  endfunction

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      green_q <= '0;
      inv_q   <= '0;
      ack_q   <= 1'b0;
      fight_q <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      green_q <= green_nxt;
      inv_q   <= inv_nxt;
      ack_q   <= accept;
      fight_q <= (state_nxt == FIGHT);
      lose_q  <= (state_nxt == LOSE);
    end
  end

  always_comb begin
    state_nxt = state_q;
    green_nxt = green_q;
    inv_nxt   = inv_q;
    accept    = 1'b0;
    clr       = 1'b0;
    if (round_start) begin
      state_nxt = FILL;
      green_nxt = '0;
      inv_nxt   = '0;
      clr       = 1'b1;
    end else begin
      unique case (state_q)
        FILL: begin
          if (frame_tick) begin
            green_nxt = sat_add(green_q, FILL_V);
            if (green_nxt == MAX_V) state_nxt = FIGHT;
          end
        end
        FIGHT, KO_DRAIN: begin
          if (state_q == FIGHT && hit_valid && inv_q == '0) begin
            accept    = 1'b1;
            green_nxt = sat_sub(green_q, {3'b000, hit_dmg});
            inv_nxt   = IV_LOAD;
            if (green_nxt == '0) state_nxt = KO_DRAIN;
          end else begin
            if (frame_tick && inv_q != '0) inv_nxt = inv_q - 1'b1;
            // red_w == 0 is already registered, so LOSE lands one cycle later.
            if (state_q == KO_DRAIN && red_w == '0) state_nxt = LOSE;
          end
        end
        default: ;
      endcase
    end
  end

  // Red mirrors green outside the fight; trail timing runs only in FIGHT/KO_DRAIN.
  assign track = (state_q == IDLE) || (state_q == FILL) || (state_q == LOSE);
  assign run   = (state_q == FIGHT) || (state_q == KO_DRAIN);

  hb_trail #(
    .TRAIL_DELAY(TRAIL_DELAY),
    .DRAIN_STEP (DRAIN_STEP)
  ) u_trail (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .frame_tick(frame_tick),
    .clr       (clr),
    .load      (accept),
    .track     (track),
    .run       (run),
    .green_w   (green_nxt),
    .red_w     (red_w)
  );

  assign greensizex   = green_q;
  assign redsizex     = red_w;
  assign fight_active = fight_q;
  assign hit_ack      = ack_q;
  assign lose         = lose_q;

endmodule

// File: tb/tb_health_bar_ctrl.sv
// Randomized and directed bench for health_bar_ctrl against a behavioural model.
module tb_health_bar_ctrl;

  localparam int MAXW  = 100;
  localparam int FSTEP = 2;
  localparam int DSTEP = 1;
  localparam int TDLY  = 30;
  localparam int INV   = 20;

  logic       CLK = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       round_start = 1'b0;
  logic       hit_valid = 1'b0;
  logic [6:0] hit_dmg = '0;
  logic [9:0] greensizex, redsizex;
  logic       fight_active, hit_ack, lose;

  int checks = 0;
  int errors = 0;

  typedef enum int {M_IDLE, M_FILL, M_FIGHT, M_KO, M_LOSE} mstate_t;
  mstate_t ms;
  int mg, mr, minv, mtr;
  bit mack;

  always #5 CLK = ~CLK;

  health_bar_ctrl dut (
    .CLK         (CLK),
    .Reset_n     (Reset_n),
    .frame_tick  (frame_tick),
    .round_start (round_start),
    .hit_valid   (hit_valid),
    .hit_dmg     (hit_dmg),
    .greensizex  (greensizex),
    .redsizex    (redsizex),
    .fight_active(fight_active),
    .hit_ack     (hit_ack),
    .lose        (lose)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms = M_IDLE; mg = 0; mr = 0; minv = 0; mtr = 0; mack = 0;
  endtask

  // One clock of the game rules, applied to the inputs present in that cycle.
  task automatic model_step(input bit rs, input bit hv, input int dmg, input bit ft);
    mack = 0;
    if (rs) begin
      ms = M_FILL; mg = 0; mr = 0; minv = 0; mtr = 0;
    end else if (ms == M_FILL) begin
      if (ft) begin
        mg = (mg + FSTEP > MAXW) ? MAXW : mg + FSTEP;
        mr = mg;
        if (mg == MAXW) ms = M_FIGHT;
      end
    end else if (ms == M_FIGHT || ms == M_KO) begin
      if (ms == M_FIGHT && hv && minv == 0) begin
        mack = 1;
        mg   = (dmg > mg) ? 0 : mg - dmg;
        minv = INV;
        mtr  = TDLY;
        if (mg == 0) ms = M_KO;
      end else begin
        if (ms == M_KO && mr == 0) ms = M_LOSE;
        if (ft) begin
          if (minv > 0) minv--;
          if (mtr > 0) mtr--;
          else if (mr > mg) mr -= ((mr - mg) < DSTEP) ? (mr - mg) : DSTEP;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("green", greensizex, mg);
    chk("red", redsizex, mr);
    chk("fight_active", fight_active, (ms == M_FIGHT));
    chk("hit_ack", hit_ack, mack);
    chk("lose", lose, (ms == M_LOSE));
  endtask

  task automatic cyc(input bit rs, input bit hv, input int dmg, input bit ft);
    round_start = rs;
    hit_valid   = hv;
    hit_dmg     = 7'(dmg);
    frame_tick  = ft;
    model_step(rs, hv, dmg, ft);
    @(posedge CLK);
    #1;
    compare_all();
    round_start = 1'b0;
    hit_valid   = 1'b0;
    frame_tick  = 1'b0;
  endtask

  task automatic tick();
    cyc(0, 0, 0, 1);
  endtask

  task automatic async_reset();
    Reset_n = 1'b0;
    model_reset();
    #2;
    compare_all();
    @(posedge CLK);
    #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    int zero_c, lose_c;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    Reset_n = 1'b1;
    compare_all();
    chk("reset_green", greensizex, 0);
    chk("reset_lose", lose, 0);

    // Intro fill: 2,4,...,100 with fight_active rising on the last step.
    cyc(1, 0, 0, 0);
    for (int k = 1; k <= 50; k++) begin
      tick();
      chk("fill_green", greensizex, 2 * k);
      chk("fill_fight", fight_active, (k == 50));
    end

    // Hit of 30, then trail holds for 30 ticks and drains to 70.
    cyc(0, 1, 30, 0);
    chk("hit30_green", greensizex, 70);
    chk("hit30_ack", hit_ack, 1);
    cyc(0, 0, 0, 0);
    chk("ack_pulse", hit_ack, 0);
    for (int t = 1; t <= 60; t++) begin
      tick();
      if (t == 30) chk("trail_hold", redsizex, 100);
      if (t == 31) chk("trail_first", redsizex, 99);
      if (t == 60) chk("trail_done", redsizex, 70);
    end

    // Invulnerability window.
    cyc(0, 1, 10, 0);
    chk("hit10_green", greensizex, 60);
    for (int t = 1; t <= 19; t++) tick();
    cyc(0, 1, 10, 0);
    chk("inv_ack", hit_ack, 0);
    chk("inv_green", greensizex, 60);
    tick();
    cyc(0, 1, 10, 0);
    chk("after_inv_ack", hit_ack, 1);
    chk("after_inv_green", greensizex, 50);
    for (int t = 1; t <= 20; t++) tick();
    cyc(0, 1, 10, 1);
    chk("hit_tick_green", greensizex, 40);
    for (int t = 1; t <= 20; t++) tick();

    // Knockout and lose timing.
    cyc(0, 1, 127, 0);
    chk("ko_green", greensizex, 0);
    chk("ko_fight", fight_active, 0);
    zero_c = -1;
    lose_c = -1;
    for (int c = 0; c < 400 && lose_c < 0; c++) begin
      tick();
      if (zero_c < 0 && redsizex == 0) zero_c = c;
      if (lose_c < 0 && lose == 1'b1) lose_c = c;
    end
    chk("lose_reached", (lose_c >= 0), 1);
    chk("lose_after_red0", lose_c, zero_c + 1);

    // round_start beats hit and tick in LOSE.
    cyc(1, 1, 50, 1);
    chk("restart_green", greensizex, 0);
    chk("restart_ack", hit_ack, 0);
    chk("restart_lose", lose, 0);

    // Async reset in the middle of a trail drain.
    for (int k = 1; k <= 50; k++) tick();
    cyc(0, 1, 60, 0);
    for (int t = 1; t <= 35; t++) tick();
    chk("pre_reset_red", redsizex, 95);
    async_reset();
    chk("rst_red", redsizex, 0);
    chk("rst_green", greensizex, 0);
    cyc(0, 1, 20, 0);
    chk("idle_hit_ack", hit_ack, 0);

    // Randomized play.
    cyc(1, 0, 0, 0);
    for (int n = 0; n < 20000; n++) begin
      bit rs, hv, ft;
      int dmg;
      if ($urandom_range(0, 2999) == 0) begin
        async_reset();
        cyc(1, 0, 0, 0);
      end
      rs  = ($urandom_range(0, 599) == 0);
      ft  = ($urandom_range(0, 2) == 0);
      hv  = ($urandom_range(0, 3) == 0);
      dmg = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 25));
      if (ms == M_LOSE && $urandom_range(0, 19) == 0) rs = 1'b1;
      cyc(rs, hv, dmg, ft);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
